reg_share_arbiter: RTL

//   Shares one WIDTH-bit holding register among NUM_REQ writers. Each cycle, at most
//   one requester wins by round-robin; its data is loaded into the register on that edge.
//   A writer may lock the register for a burst of back-to-back writes. The lock is

---
 rtl/reg_share_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that loads one shared holding register from NUM_REQ writers,
// with an optional bounded lock that lets the current owner issue back-to-back writes.
module reg_share_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [WIDTH-1:0]         out,
    output logic [ID_W-1:0]          owner,
    output logic                     out_valid,
    output logic                     locked
);

    localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(LOCK_MAX - 1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                out_valid_q, out_valid_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
        if (32'(p) == NUM_REQ - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_cnt_d  = lock_cnt_q;
        out_d       = out_q;
        owner_d     = owner_q;
        grant_d     = '0;
        out_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    out_d          = data_in[32'(win_idx)*WIDTH +: WIDTH];
                    owner_d        = win_idx;
                    grant_d[win_idx] = 1'b1;
                    out_valid_d    = 1'b1;
                    rr_ptr_d       = next_ptr(win_idx);
                    if (lock[win_idx]) begin
                        state_d    = StLocked;
                        lock_cnt_d = '0;
                    end
                end
            end
            StLocked: begin
                if (req[owner_q]) begin
                    out_d            = data_in[32'(owner_q)*WIDTH +: WIDTH];
                    grant_d[owner_q] = 1'b1;
                    out_valid_d      = 1'b1;
                end
                // Exit edge never arbitrates; others compete from the next edge on.
                if (!lock[owner_q] || lock_cnt_q == LastCnt) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                    rr_ptr_d   = next_ptr(owner_q);
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            lock_cnt_q  <= '0;
            out_q       <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            out_q       <= out_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign grant     = grant_q;
    assign out       = out_q;
    assign owner     = owner_q;
    assign out_valid = out_valid_q;
    assign locked    = (state_q == StLocked);

endmodule
